// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one main-memory port between instruction-cache refills and
//   memory-stage traffic (data-cache refills and write-through stores).
//   It holds one request at a time. A refill runs as BLOCK_WORDS beats,
//   and each returned word goes back to the requesting cache. A store
//   runs as a single write beat.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   i_req, i_addr, i_done         instruction-cache miss request / completion pulse
//   d_req, d_we, d_addr, d_wdata  memory-stage request (store or refill)
//   d_done                        memory-stage completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack main-memory beat interface (registered outputs)
//   fill_valid, fill_dest,
//   fill_idx, fill_data           fill-word stream back to the caches
//   stall                         pipeline freeze while a request is pending
module cache_refill_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    output logic                           i_done,
    input  logic                           d_req,
    input  logic                           d_we,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [DATA_W-1:0]              d_wdata,
    output logic                           d_done,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_ack,
    output logic                           fill_valid,
    output logic                           fill_dest,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]              fill_data,
    output logic                           stall
);

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_I_FILL  = 3'd1;
    localparam logic [2:0] ST_D_FILL  = 3'd2;
    localparam logic [2:0] ST_D_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]        state;
    logic              last_d;     // 1 when the data side received the most recent grant
    logic [IDX_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_addr;

    logic              grant_d;
    logic              beat;
    logic [ADDR_W-1:0] i_base;
    logic [ADDR_W-1:0] d_base;
    logic [ADDR_W-1:0] d_word;
    logic [ADDR_W-1:0] next_off;
    logic              unused_addr_bits;

    // On a tie, grant the side that did not win the previous grant.
    assign grant_d = d_req & (~i_req | ~last_d);

    // A beat counts only when a request is outstanding, so a stray ack has no effect.
    assign beat = mem_req & mem_ack;

    assign i_base   = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign d_base   = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign d_word   = {d_addr[ADDR_W-1:2], 2'b00};
    assign next_off = (ADDR_W'(cnt) + ADDR_W'(1)) << 2;

    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[1:0]};

    assign stall = ((state != ST_IDLE) && (state != ST_DONE)) ||
                   ((state == ST_IDLE) && (i_req || d_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_d     <= 1'b0;
            cnt        <= '0;
            base_addr  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fill_valid <= 1'b0;
            fill_dest  <= 1'b0;
            fill_idx   <= '0;
            fill_data  <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        last_d  <= grant_d;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (grant_d && d_we) begin
                            state     <= ST_D_WRITE;
                            base_addr <= d_word;
                            mem_we    <= 1'b1;
                            mem_addr  <= d_word;
                            mem_wdata <= d_wdata;
                        end else if (grant_d) begin
                            state     <= ST_D_FILL;
                            base_addr <= d_base;
                            mem_addr  <= d_base;
                        end else begin
                            state     <= ST_I_FILL;
                            base_addr <= i_base;
                            mem_addr  <= i_base;
                        end
                    end
                end
                ST_I_FILL, ST_D_FILL: begin
                    if (beat) begin
                        fill_valid <= 1'b1;
                        fill_idx   <= cnt;
                        fill_data  <= mem_rdata;
                        fill_dest  <= (state == ST_D_FILL);
                        // BLOCK_WORDS is a power of two, so all-ones marks the last beat.
                        if (&cnt) begin
                            state    <= ST_DONE;
                            mem_req  <= 1'b0;
                            mem_addr <= '0;
                            i_done   <= (state == ST_I_FILL);
                            d_done   <= (state == ST_D_FILL);
                        end else begin
                            cnt      <= cnt + 1'b1;
                            mem_addr <= base_addr + next_off;
                        end
                    end
                end
                ST_D_WRITE: begin
                    if (beat) begin
                        state     <= ST_DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        d_done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Shares a single main-memory port between instruction-cache refills and data-memory-stage traffic (cache-miss refills and write-through stores).
- Sits between the fetch stage, the memory stage and main memory.
- Latches one request at a time, sequences a BLOCK_WORDS-beat refill or a single-beat store, and streams fill words back to the requesting cache.
- Raises `stall` to freeze the pipeline while a request is pending.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width
- BLOCK_WORDS, 4, words per cache block; power of two, >= 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  instruction-cache miss request; held until i_done
- i_addr  in  ADDR_W  miss byte address
- i_done  out  1  one-cycle pulse: I-refill complete
- d_req  in  1  memory-stage request; held until d_done
- d_we  in  1  1 = single-word store, 0 = block refill
- d_addr  in  ADDR_W  byte address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse: data request complete
- mem_req  out  1  memory beat request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address (byte address, low 2 bits 0)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  beat completes on an edge where mem_req & mem_ack
- fill_valid  out  1  fill word valid this cycle
- fill_dest  out  1  0 = I-cache, 1 = D-cache
- fill_idx  out  log2(BLOCK_WORDS)  word index within block
- fill_data  out  DATA_W  fill word
- stall  out  1  pipeline freeze

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, beat counter=0, last_grant=I (so first tie goes to data).
  - All registered outputs 0; latched address and data 0.
  - Reset mid-transfer abandons the transfer; no done pulse is issued.
- States: IDLE, I_FILL, D_FILL, D_WRITE, DONE.
- IDLE arbitration:
  - Only d_req: d_we=1 -> D_WRITE, else D_FILL.
  - Only i_req: -> I_FILL.
  - Both: grant the opposite of last_grant (round-robin), then update last_grant.
- At grant:
  - Latch address. Fill states use the block base: low log2(BLOCK_WORDS)+2 bits cleared. D_WRITE uses the word address: low 2 bits cleared.
  - Latch d_wdata and d_we.
  - Clear counter. Requester inputs are ignored until DONE.
- FILL states:
  - mem_req=1, mem_we=0, mem_addr = base + counter*4.
  - On each edge with mem_ack=1: the next cycle has fill_valid=1, fill_data = captured mem_rdata, fill_idx = counter value of that beat, fill_dest = requester. Counter increments.
  - Words are filled in order 0..BLOCK_WORDS-1 with no wrap; there is no critical-word-first ordering.
  - mem_ack=0 inserts wait cycles indefinitely; mem_addr is held.
  - Ack of the last beat -> DONE.
- D_WRITE: mem_req=1, mem_we=1, mem_addr and mem_wdata from latches; on ack -> DONE. fill_valid stays 0.
- DONE (exactly one cycle):
  - i_done or d_done=1 for the served requester; mem_req=0; then -> IDLE.
  - The requester must drop req at the edge ending DONE. A req still high in the following IDLE cycle is a new request.
- Output timing:
  - mem_req, mem_we, mem_addr and mem_wdata are registered. They change only at edges and are 0 in IDLE and DONE.
  - No beat ever occurs with mem_req=0, regardless of mem_ack.
- Latency: IDLE grant edge, then the first mem_req cycle. The minimum refill is 1 + BLOCK_WORDS + 1 cycles from req to done with mem_ack tied high.
- stall = (state != IDLE && state != DONE) | (state == IDLE & (i_req | d_req)). Combinational; 0 during DONE so the pipeline advances with the done pulse.
- A spurious mem_ack in IDLE or DONE is ignored.

Test Plan:
- Reset/idle: rst_n=0 mid-D_FILL at beat 2, then release -> all outputs 0, state IDLE, no d_done; the next d_req restarts at beat 0.
- I-refill: i_req=1, i_addr=0x0000_0134, mem_ack=1 constant, mem_rdata=0xA0+index -> mem_addr 0x130, 0x134, 0x138, 0x13C. Four fill_valid pulses with fill_dest=0, fill_idx 0..3, data 0xA0..0xA3. i_done one cycle later; stall falls with DONE.
- Store: d_req=1, d_we=1, d_addr=0x0000_0207, d_wdata=0xDEADBEEF, mem_ack delayed 3 cycles -> mem_we=1, mem_addr=0x204, data held over 3 wait cycles. d_done after ack; no fill_valid.
- Tie round-robin: i_req and d_req rise in the same cycle after reset -> data served first, then I. Repeat the tie -> data served first again, since last_grant=I after the second service.
- Wait states: D-refill with mem_ack toggling 1,0,0,1,0,1,1 -> exactly 4 fill beats, idx 0..3, mem_addr stable during waits.
- Request hold: i_addr changed to 0x500 mid-refill of 0x100 -> all beats still address the 0x100 block.
